// File: rtl/bitcnt_pkg.sv
// Shared types and width helpers for the sequential bit-count unit.
package bitcnt_pkg;

  typedef enum logic [1:0] {
    BC_POPCNT = 2'b00,
    BC_CLZ    = 2'b01,
    BC_CTZ    = 2'b10
  } bc_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } bc_state_e;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Encoding 11 falls back to popcount.
  function automatic bc_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return BC_CLZ;
      2'b10:   return BC_CTZ;
      default: return BC_POPCNT;
    endcase
  endfunction

endpackage

// File: rtl/chunk_cnt.sv
// Combinational popcount / trailing-zero count / zero flag for one chunk.
module chunk_cnt
  import bitcnt_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0]     chunk_i,
  output logic [$clog2(CHUNK):0] popcnt_o,
  output logic [$clog2(CHUNK):0] tzcnt_o,
  output logic                 zero_o
);

  localparam int KW = cnt_width(CHUNK);

  always_comb begin
    popcnt_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      popcnt_o = popcnt_o + KW'(chunk_i[i]);
    end
  end

  // An all-zero chunk yields CHUNK, which is exactly the clz/ctz increment.
  always_comb begin
    tzcnt_o = KW'(CHUNK);
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (chunk_i[i]) tzcnt_o = KW'(i);
    end
  end

  assign zero_o = ~|chunk_i;

endmodule

// File: rtl/bitcnt_seq.sv
// Multi-cycle popcount / clz / ctz unit; one CHUNK per cycle, clz handled as ctz of the reversed operand.
module bitcnt_seq
  import bitcnt_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [WIDTH-1:0]       Num,
  input  logic [1:0]             Mode,
  input  logic                   W32,
  input  logic                   Flush,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [$clog2(WIDTH):0] Count,
  output logic                   Busy
);

  localparam int CW  = cnt_width(WIDTH);
  localparam int KW  = cnt_width(CHUNK);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = idx_width(NCH);
  localparam logic [IW-1:0]    LAST_FULL = IW'(NCH - 1);
  localparam logic [IW-1:0]    LAST_W32  = IW'(32 / CHUNK - 1);
  localparam logic [WIDTH-1:0] LOW32     = WIDTH'({32{1'b1}});

  bc_state_e        state_q, state_d;
  bc_mode_e         mode_q;
  bc_mode_e         mode_dec;
  logic [WIDTH-1:0] op_q;
  logic [IW-1:0]    idx_q, last_q;
  logic [CW-1:0]    acc_q, count_q;

  logic             narrow, accept, last_chunk, term;
  logic [WIDTH-1:0] rev_full, rev_w32, op_capture;
  logic [CHUNK-1:0] chunk;
  logic [KW-1:0]    chunk_pop, chunk_tz;
  logic             chunk_zero;
  logic [CW-1:0]    sum;

  assign narrow   = W32 && (WIDTH > 32);
  assign mode_dec = decode_mode(Mode);
  assign accept   = InValid && InReady;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign rev_full[gi] = Num[WIDTH-1-gi];
      if (gi < 32) begin : g_lo
        assign rev_w32[gi] = Num[31-gi];
      end else begin : g_hi
        assign rev_w32[gi] = 1'b0;
      end
    end
  endgenerate

  // Bits above the active width are zeroed so they never contribute.
  always_comb begin
    if (mode_dec == BC_CLZ) op_capture = narrow ? rev_w32 : rev_full;
    else                    op_capture = narrow ? (Num & LOW32) : Num;
  end

  assign chunk = op_q[CHUNK*int'(idx_q) +: CHUNK];

  chunk_cnt #(.CHUNK(CHUNK)) u_chunk_cnt (
    .chunk_i  (chunk),
    .popcnt_o (chunk_pop),
    .tzcnt_o  (chunk_tz),
    .zero_o   (chunk_zero)
  );

  assign sum        = acc_q + CW'((mode_q == BC_POPCNT) ? chunk_pop : chunk_tz);
  assign last_chunk = (idx_q == last_q);
  assign term       = last_chunk || ((mode_q != BC_POPCNT) && !chunk_zero);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (InValid)  state_d = RUN;
        RUN:     if (term)     state_d = DONE;
        DONE:    if (OutReady) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    InReady  = (state_q == IDLE) && !Flush;
    OutValid = (state_q == DONE);
    Busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q    <= '0;
      mode_q  <= BC_POPCNT;
      last_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else if (Flush) begin
      acc_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      op_q   <= op_capture;
      mode_q <= mode_dec;
      last_q <= narrow ? LAST_W32 : LAST_FULL;
      acc_q  <= '0;
      idx_q  <= '0;
    end else if (state_q == RUN) begin
      acc_q <= sum;
      idx_q <= idx_q + IW'(1);
      if (term) count_q <= sum;
    end
  end

  assign Count = count_q;

endmodule

// File: tb/tb_bitcnt_seq.sv
// Scoreboard bench for bitcnt_seq (WIDTH=64, CHUNK=16): expectations queued at accept, checked on output.
module tb_bitcnt_seq;

  localparam int WIDTH = 64;
  localparam int CHUNK = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        InValid;
  logic        InReady;
  logic [63:0] Num;
  logic [1:0]  Mode;
  logic        W32;
  logic        Flush;
  logic        OutValid;
  logic        OutReady;
  logic [6:0]  Count;
  logic        Busy;

  bitcnt_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .InValid  (InValid),
    .InReady  (InReady),
    .Num      (Num),
    .Mode     (Mode),
    .W32      (W32),
    .Flush    (Flush),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Count    (Count),
    .Busy     (Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] count;
    int         due;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   ov_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model(input logic [1:0] m, input logic w, input logic [63:0] n,
                                output logic [6:0] c, output int lat);
    int nw;
    nw = w ? 32 : 64;
    c  = '0;
    if (m == 2'b01) begin
      c = 7'(nw);
      for (int i = 0; i < nw; i++) if (n[i]) c = 7'(nw - 1 - i);
    end else if (m == 2'b10) begin
      c = 7'(nw);
      for (int i = nw - 1; i >= 0; i--) if (n[i]) c = 7'(i);
    end else begin
      for (int i = 0; i < nw; i++) c = c + 7'(n[i]);
    end
    if (m == 2'b01 || m == 2'b10) lat = (int'(c) == nw) ? nw / 16 : int'(c) / 16 + 1;
    else                          lat = nw / 16;
  endfunction

  // Output side: latency checked on the first OutValid cycle, Count on the handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      ov_seen = 1'b0;
    end else begin
      if (OutValid && !ov_seen) begin
        ov_seen = 1'b1;
        if (sb.size() == 0) check_eq("spurious_outvalid", OutValid, 1'b0);
        else                check_eq({sb[0].tag, "_latency"}, 64'(cyc), 64'(sb[0].due));
      end
      if (OutValid && OutReady) begin
        ov_seen = 1'b0;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq({e.tag, "_count"}, Count, e.count);
          $display("txn %-14s count=%0d expected=%0d cycle=%0d", e.tag, Count, e.count, cyc);
        end
      end
    end
  end

  task automatic start_op(input string tag, input logic [1:0] m, input logic w,
                          input logic [63:0] n, input logic [6:0] c, input int lat, input bit push);
    int   guard;
    exp_t e;
    guard = 0;
    while (!InReady && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!InReady) check_eq({tag, "_inready_timeout"}, InReady, 1'b1);
    Mode = m; W32 = w; Num = n; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    // Scramble operands after accept: the unit must have latched them.
    Mode = 2'b01; W32 = ~w; Num = ~n;
    if (push) begin
      e.count = c; e.due = cyc + lat; e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((sb.size() != 0 || Busy) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq({tag, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [1:0]  rm;
    logic        rw;
    logic [63:0] rn;
    logic [6:0]  rc;
    int          rl;

    resetn = 1'b0; InValid = 1'b0; Num = '0; Mode = 2'b00; W32 = 1'b0;
    Flush = 1'b0; OutReady = 1'b1;
    #12;
    check_eq("rst_count", Count, 7'd0);
    check_eq("rst_outvalid", OutValid, 1'b0);
    check_eq("rst_busy", Busy, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_inready", InReady, 1'b1);

    start_op("pop_mix", 2'b00, 1'b0, 64'hFFFF_0000_FFFF_0001, 7'd33, 4, 1'b1); drain("pop_mix");
    start_op("ctz_b24", 2'b10, 1'b0, 64'h0000_0000_0100_0000, 7'd24, 2, 1'b1); drain("ctz_b24");
    start_op("ctz_zero", 2'b10, 1'b0, 64'h0, 7'd64, 4, 1'b1); drain("ctz_zero");
    start_op("clz_w32", 2'b01, 1'b1, 64'hFFFF_FFFF_0000_0001, 7'd31, 2, 1'b1); drain("clz_w32");
    start_op("clz_msb", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 7'd0, 1, 1'b1); drain("clz_msb");
    start_op("mode11_pop", 2'b11, 1'b0, 64'hFF, 7'd8, 4, 1'b1); drain("mode11_pop");
    start_op("pop_w32_ones", 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 7'd32, 2, 1'b1); drain("pop_w32_ones");
    start_op("ctz_w32_zero", 2'b10, 1'b1, 64'hFFFF_FFFF_0000_0000, 7'd32, 2, 1'b1); drain("ctz_w32_zero");
    start_op("clz_w32_hi", 2'b01, 1'b1, 64'h0000_0001_0000_0000, 7'd32, 2, 1'b1); drain("clz_w32_hi");
    start_op("ctz_b63", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 7'd63, 4, 1'b1); drain("ctz_b63");

    for (int k = 0; k < 10; k++) begin
      rm = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      rn = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rn = rn << $urandom_range(0, 63);
      else                           rn = rn >> $urandom_range(0, 63);
      model(rm, rw, rn, rc, rl);
      start_op($sformatf("rand%0d", k), rm, rw, rn, rc, rl, 1'b1);
      drain($sformatf("rand%0d", k));
    end

    // Backpressure: result held, new requests refused.
    OutReady = 1'b0;
    start_op("bp_pop", 2'b00, 1'b0, 64'h0F0F, 7'd8, 4, 1'b1);
    for (int g = 0; g < 20 && !OutValid; g++) begin
      @(posedge clk); #1;
    end
    check_eq("bp_reached_done", OutValid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      InValid = k[0];
      Num = 64'hFFFF;
      Mode = 2'b00;
      @(posedge clk); #1;
      check_eq("bp_outvalid_hold", OutValid, 1'b1);
      check_eq("bp_count_hold", Count, 7'd8);
      check_eq("bp_inready_low", InReady, 1'b0);
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_outvalid", OutValid, 1'b0);
    check_eq("bp_release_inready", InReady, 1'b1);
    start_op("bp_next", 2'b00, 1'b0, 64'h7, 7'd3, 4, 1'b1);
    check_eq("bp_next_busy", Busy, 1'b1);
    drain("bp_next");

    // Flush in the second RUN cycle, with a request on the same cycle.
    start_op("flush_victim", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 4, 1'b0);
    @(posedge clk); #1;
    Flush = 1'b1; InValid = 1'b1; Mode = 2'b00; Num = 64'h1;
    check_eq("flush_inready", InReady, 1'b0);
    @(posedge clk); #1;
    Flush = 1'b0; InValid = 1'b0;
    check_eq("flush_busy", Busy, 1'b0);
    check_eq("flush_outvalid", OutValid, 1'b0);
    check_eq("flush_count_kept", Count, 7'd3);
    start_op("post_flush", 2'b00, 1'b0, 64'h0F, 7'd4, 4, 1'b1);
    drain("post_flush");

    // Asynchronous reset mid-RUN.
    start_op("rst_victim", 2'b00, 1'b0, 64'hFF, 7'd8, 4, 1'b0);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check_eq("arst_outvalid", OutValid, 1'b0);
    check_eq("arst_busy", Busy, 1'b0);
    check_eq("arst_count", Count, 7'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_inready", InReady, 1'b1);
    start_op("post_rst", 2'b00, 1'b0, 64'h3, 7'd2, 4, 1'b1);
    drain("post_rst");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bitcnt_seq.md
Name: bitcnt_seq

Overview:
- Multi-cycle, parametrised bit-count unit for the bit-manipulation path.
- Computes population count, count-leading-zeros or count-trailing-zeros on a WIDTH-bit operand.
- Processes CHUNK bits per cycle. clz/ctz terminate early when the first set bit is found.
- Uses a valid/ready handshake on both input and output, with word mode (W32) for 32-bit ops on a 64-bit datapath.

Parameters:
- WIDTH, 64, operand width. Must be a power of 2, at least 32.
- CHUNK, 16, bits processed per cycle. Must be a power of 2 that divides 32.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous, active-low reset. One clock domain; all state resets asynchronously on resetn low.
- InValid  input  1  operation request.
- InReady  output  1  unit can accept a request.
- Num  input  WIDTH  operand.
- Mode  input  2  operation select: 00 popcnt, 01 clz, 10 ctz, 11 treated as popcnt.
- W32  input  1  operate on Num[31:0] only. Ignored when WIDTH==32.
- Flush  input  1  synchronous abort.
- OutValid  output  1  result available.
- OutReady  input  1  consumer takes the result.
- Count  output  $clog2(WIDTH)+1  result.
- Busy  output  1  state != IDLE.

Behaviour:
- Reset values (resetn low, effective immediately):
  - State IDLE.
  - Count 0, OutValid 0, Busy 0.
  - Accumulator and chunk index 0.
- States: IDLE, RUN, DONE.
- InReady = (state==IDLE) && !Flush. Purely combinational; no overlap of operations.
- Accept:
  - Occurs on the edge where InValid && InReady. Call this edge E0.
  - Latches the operand, Mode and NW (NW = 32 if W32 && WIDTH>32, else WIDTH).
  - Clears the accumulator and chunk index, then goes to RUN.
  - For clz, the latched operand is the bit-reverse of Num[NW-1:0]. clz is therefore computed as ctz.
  - Bits above NW are zeroed at capture.
- RUN: each edge processes chunk k (bits k*CHUNK +: CHUNK), LSB chunk first.
  - popcnt: acc += popcount(chunk).
  - clz/ctz, chunk zero: acc += CHUNK.
  - clz/ctz, chunk nonzero: acc += trailing zeros of the chunk, and the op terminates.
  - The edge processing the last chunk (k = NW/CHUNK-1), or a terminating chunk, loads Count with the final sum and goes to DONE.
- Latency (OutValid high after edge):
  - popcnt: E0+NW/CHUNK.
  - clz/ctz: E0+j+1, where j is the index of the first nonzero chunk.
  - clz/ctz on an all-zero operand: E0+NW/CHUNK, with Count = NW.
- DONE:
  - OutValid=1. Count is stable until OutValid && OutReady.
  - On that edge: go to IDLE and drop OutValid.
  - No bypass: the next accept is possible one cycle later at the earliest.
- Count holds its last value while IDLE or RUN. It is meaningful only while OutValid=1.
- Flush:
  - Highest priority. On the edge where Flush=1, from any state: go to IDLE, OutValid=0, accumulator cleared. Count is unchanged.
  - Flush with InValid in the same cycle: no accept.
  - Flush in DONE with OutReady=1: result discarded.
- Width rules:
  - Accumulator is $clog2(WIDTH)+1 bits; maximum value WIDTH, no overflow.
  - Per-chunk count is $clog2(CHUNK)+1 bits, zero-extended.
- Reset mid-operation: immediate IDLE and all outputs zero. An operation in flight is lost, with no partial output.
- Mode and W32 are sampled only at accept; changes during RUN have no effect.

Decomposition:
- Shared package bitcnt_pkg:
  - Mode enum (BC_POPCNT, BC_CLZ, BC_CTZ).
  - State enum (IDLE, RUN, DONE).
  - Width localparam helpers.
- One combinational sub-module, chunk_cnt #(CHUNK):
  - Input: chunk.
  - Outputs: popcount, trailing-zero count and zero flag of one chunk.
  - Instantiated once and muxed by latched mode.

Test Plan (WIDTH=64, CHUNK=16 unless noted):
- popcnt Num=0xFFFF_0000_FFFF_0001, W32=0 -> Count=33, OutValid high after E0+4.
- ctz Num=0x0000_0000_0100_0000 -> Count=24, OutValid after E0+2. ctz Num=0 -> Count=64 after E0+4.
- clz W32=1, Num=0xFFFF_FFFF_0000_0001 -> Count=31 after E0+2. clz W32=0, Num=0x8000_0000_0000_0000 -> Count=0 after E0+1.
- Backpressure: OutReady low 5 cycles in DONE -> OutValid/Count stable, InReady=0, InValid pulses ignored. OutReady high -> IDLE next edge, new op accepted the edge after.
- Flush at 2nd RUN cycle of popcnt 0xFFFF..FF, then popcnt 0x0F accepted next cycle -> single OutValid with Count=4, no stale result.
- resetn low mid-RUN -> OutValid/Count/Busy go 0 asynchronously. After release, InReady=1 and popcnt 0x3 -> Count=2.
